// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: the instruction-FIFO entry layout and its default depth.
package cpu_defs_pkg;

    localparam int INST_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction FIFO storage: DEPTH entries with two synchronous write ports and
// two asynchronous read ports (head and head+1 for first-word-fall-through).
module inst_fifo_mem
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we1,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [$clog2(DEPTH)-1:0] waddr2,
    input  fifo_entry_t              wdata1,
    input  fifo_entry_t              wdata2,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output fifo_entry_t              rdata1,
    output fifo_entry_t              rdata2
);

    fifo_entry_t mem [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // pointers and count, so clearing the array would only cost reset fan-out.
    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
        if (we2) mem[waddr2] <= wdata2;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction FIFO between fetch and decode (first-word-fall-through).
// Optional performance counters are built when INST_FIFO_PERF_EN is defined.
module inst_fifo
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en1,
    input  logic                   wr_en2,
    input  logic [31:0]            wr_inst1,
    input  logic [31:0]            wr_inst2,
    input  logic [31:0]            wr_pc1,
    input  logic [31:0]            wr_pc2,
    input  logic                   rd_en1,
    input  logic                   rd_en2,
    output logic [31:0]            rd_inst1,
    output logic [31:0]            rd_inst2,
    output logic [31:0]            rd_pc1,
    output logic [31:0]            rd_pc2,
    output logic                   rd_valid1,
    output logic                   rd_valid2,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
`ifdef INST_FIFO_PERF_EN
    ,
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [1:0]       pushes;
    logic [1:0]       pops;
    logic             we1;
    logic             we2;
    fifo_entry_t      wdata1;
    fifo_entry_t      wdata2;
    fifo_entry_t      rdata1;
    fifo_entry_t      rdata2;

    // Status comes from the registered count only, so push and pop never interact combinationally.
    assign empty     = (count == '0);
    assign full      = (count > CNT_W'(DEPTH - 2));
    assign rd_valid1 = (count != '0);
    assign rd_valid2 = (count >= CNT_W'(2));

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        pops   = 2'd0;
        pushes = 2'd0;
        if (rd_en1 && rd_en2 && rd_valid2) pops = 2'd2;
        else if (rd_en1 && rd_valid1)      pops = 2'd1;
        if (!full && wr_en1) pushes = wr_en2 ? 2'd2 : 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pops);
            wr_ptr <= wr_ptr + PTR_W'(pushes);
            count  <= count + CNT_W'(pushes) - CNT_W'(pops);
        end
    end

    assign we1    = !rst && !flush && (pushes != 2'd0);
    assign we2    = !rst && !flush && (pushes == 2'd2);
    assign wdata1 = '{pc: wr_pc1, inst: wr_inst1};
    assign wdata2 = '{pc: wr_pc2, inst: wr_inst2};

    inst_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we1    (we1),
        .we2    (we2),
        .waddr1 (wr_ptr),
        .waddr2 (wr_ptr + PTR_W'(1)),
        .wdata1 (wdata1),
        .wdata2 (wdata2),
        .raddr1 (rd_ptr),
        .raddr2 (rd_ptr + PTR_W'(1)),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign rd_inst1 = rdata1.inst;
    assign rd_pc1   = rdata1.pc;
    assign rd_inst2 = rdata2.inst;
    assign rd_pc2   = rdata2.pc;

`ifdef INST_FIFO_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_cycles <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (full)  perf_full_cycles <= perf_full_cycles + 32'd1;
            if (flush) perf_flush_cnt   <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue-based reference model pushes the
// expected post-edge state; a monitor pops and compares it against the DUT.
module tb_inst_fifo;
    import cpu_defs_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        int          cnt;
        bit          empty;
        bit          full;
        bit          v1;
        bit          v2;
        fifo_entry_t e1;
        fifo_entry_t e2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0, flush = 1'b0;
    logic          wr_en1 = 1'b0, wr_en2 = 1'b0, rd_en1 = 1'b0, rd_en2 = 1'b0;
    logic [31:0]   wr_inst1 = '0, wr_inst2 = '0, wr_pc1 = '0, wr_pc2 = '0;
    logic [31:0]   rd_inst1, rd_inst2, rd_pc1, rd_pc2;
    logic          rd_valid1, rd_valid2, empty, full;
    logic [CW-1:0] count;

    int            total = 0;
    int            bad   = 0;
    fifo_entry_t   mq[$];
    exp_t          exp_q[$];
    logic [31:0]   pc_base = 32'h0;
    int unsigned   seq = 0;

    always #5 clk = ~clk;

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en1(wr_en1), .wr_en2(wr_en2),
        .wr_inst1(wr_inst1), .wr_inst2(wr_inst2), .wr_pc1(wr_pc1), .wr_pc2(wr_pc2),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_inst1(rd_inst1), .rd_inst2(rd_inst2), .rd_pc1(rd_pc1), .rd_pc2(rd_pc2),
        .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
        .empty(empty), .full(full), .count(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue; rules applied to the occupancy before the edge.
    task automatic model_update(input bit r, f, w1, w2, r1, r2);
        int   n;
        int   npop;
        exp_t s;
        n = mq.size();
        if (r || f) begin
            mq.delete();
        end else begin
            npop = (r1 && r2 && n >= 2) ? 2 : ((r1 && n >= 1) ? 1 : 0);
            for (int i = 0; i < npop; i++) void'(mq.pop_front());
            if (!(n > DEPTH - 2) && w1) begin
                mq.push_back('{pc: wr_pc1, inst: wr_inst1});
                if (w2) mq.push_back('{pc: wr_pc2, inst: wr_inst2});
            end
        end
        s.cnt   = mq.size();
        s.empty = (s.cnt == 0);
        s.full  = (s.cnt > DEPTH - 2);
        s.v1    = (s.cnt >= 1);
        s.v2    = (s.cnt >= 2);
        s.e1    = s.v1 ? mq[0] : '0;
        s.e2    = s.v2 ? mq[1] : '0;
        exp_q.push_back(s);
    endtask

    task automatic step(input bit r, f, w1, w2, r1, r2);
        @(negedge clk);
        rst = r; flush = f; wr_en1 = w1; wr_en2 = w2; rd_en1 = r1; rd_en2 = r2;
        wr_pc1   = pc_base + 32'(seq * 4);
        wr_pc2   = pc_base + 32'((seq + 1) * 4);
        wr_inst1 = $urandom;
        wr_inst2 = $urandom;
        if (w1) seq += w2 ? 2 : 1;
        @(posedge clk);
        model_update(r, f, w1, w2, r1, r2);
    endtask

    task automatic restart(input logic [31:0] base);
        pc_base = base;
        seq     = 0;
        step(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares one expected snapshot per clock, sampled 1ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", 64'(count), 64'(e.cnt));
                check("empty", 64'(empty), 64'(e.empty));
                check("full", 64'(full), 64'(e.full));
                check("rd_valid1", 64'(rd_valid1), 64'(e.v1));
                check("rd_valid2", 64'(rd_valid2), 64'(e.v2));
                if (e.v1) check("head1", {rd_pc1, rd_inst1}, {e.e1.pc, e.e1.inst});
                if (e.v2) check("head2", {rd_pc2, rd_inst2}, {e.e2.pc, e.e2.inst});
            end
        end
    end

    initial begin
        // Reset state
        restart(32'h0);
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'({rd_valid1, rd_valid2}), 64'd0);

        // Dual write
        pc_base = 32'hbfc00000;
        step(0, 0, 1, 1, 0, 0);
        #2;
        check("dual_pc1", 64'(rd_pc1), 64'h0bfc00000);
        check("dual_pc2", 64'(rd_pc2), 64'h0bfc00004);
        check("dual_count", 64'(count), 64'd2);

        // Fill to full, then dropped writes
        restart(32'h2000);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0);
        #2;
        check("fill14_count", 64'(count), 64'd14);
        check("fill14_full", 64'(full), 64'd0);
        step(0, 0, 1, 1, 0, 0);
        #2;
        check("fill16_count", 64'(count), 64'd16);
        check("fill16_full", 64'(full), 64'd1);
        step(0, 0, 1, 1, 0, 0);
        #2;
        check("drop_count", 64'(count), 64'd16);
        check("drop_head", 64'(rd_pc1), 64'h2000);

        // Simultaneous push/pop across the 15->0 pointer wrap
        restart(32'h1000);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        #2;
        check("sim_pre_count", 64'(count), 64'd3);
        step(0, 0, 1, 1, 1, 1);
        #2;
        check("sim1_count", 64'(count), 64'd3);
        check("sim1_head", 64'(rd_pc1), 64'h1000 + 64'(13 * 4));
        step(0, 0, 1, 1, 1, 1);
        #2;
        check("sim2_count", 64'(count), 64'd3);
        check("sim2_head", 64'(rd_pc1), 64'h1000 + 64'(15 * 4));
        step(0, 0, 0, 0, 1, 1);
        #2;
        check("wrap_head", 64'(rd_pc1), 64'h1044);

        // Flush with same-cycle read and write
        restart(32'h3000);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
        #2;
        check("preflush_count", 64'(count), 64'd10);
        pc_base = 32'h4000;
        seq     = 0;
        step(0, 1, 1, 0, 1, 0);
        #2;
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        pc_base = 32'h5000;
        seq     = 0;
        step(0, 0, 1, 0, 0, 0);
        #2;
        check("postflush_head", 64'(rd_pc1), 64'h5000);
        check("postflush_count", 64'(count), 64'd1);

        // Single-slot rules
        restart(32'h6000);
        step(0, 0, 0, 1, 0, 0);
        #2;
        check("wr2_only_empty", 64'(count), 64'd0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        #2;
        check("wr2_only_count", 64'(count), 64'd1);
        step(0, 0, 0, 0, 1, 1);
        #2;
        check("pop1_of_2_count", 64'(count), 64'd0);
        step(0, 0, 0, 0, 0, 1);
        #2;
        check("rd2_only_count", 64'(count), 64'd0);

        // Randomized traffic
        pc_base = 32'h8000_0000;
        seq     = 0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 50);
        end
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
